// File: rtl/nbcac_decoder_rx_24.sv
// nbcac_decoder_rx_24: receive stage for the 24-wire NBCAC bus.
// Stage 1 samples codewords and checks for adjacent opposite transitions.
// Stage 2 decodes the codeword to 17 bits and queues results in a valid/ready FIFO.
// Optional macro NBCAC_RX_DATAIN_CHECK_EN re-encodes each decoded word.
// A word that does not re-encode to itself is flagged and counted like a crosstalk violation.

// Combinational decode core.
// Wires 3,6,...,21 duplicate their lower neighbour and carry no data.
module nbcac_17di_decoder_core (
    input  logic [24:1] d,
    output logic [16:0] v
);
    genvar i;
    generate
        for (i = 0; i < 16; i++) begin : g_bit
            assign v[i] = d[i + i/2 + 1];
        end
    endgenerate
    assign v[16] = d[24];
endmodule

`ifdef NBCAC_RX_DATAIN_CHECK_EN
// Combinational encode core: the inverse of the decode core.
module nbcac_17di_encoder_core (
    input  logic [16:0] v,
    output logic [24:1] d
);
    genvar m;
    generate
        for (m = 1; m <= 7; m++) begin : g_grp
            assign d[3*m-2] = v[2*m-2];
            assign d[3*m-1] = v[2*m-1];
            assign d[3*m]   = v[2*m-1];
        end
    endgenerate
    assign d[22] = v[14];
    assign d[23] = v[15];
    assign d[24] = v[16];
endmodule
`endif

module nbcac_decoder_rx_24 #(
    parameter int FIFO_DEPTH = 4,
    parameter int ERRCNT_W   = 8
) (
    input  logic                clock,
    input  logic                rst_n,
    input  logic [24:1]         codein,
    input  logic                cw_valid,
    output logic [16:0]         dataout,
    output logic                xt_err,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow,
    output logic [ERRCNT_W-1:0] err_count,
    input  logic                clr_stat
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [24:1] prev_cw, s1_cw, rise, fall;
    logic        s1_valid, s1_viol, viol, bad;
    logic [16:0] dec;
    logic [17:0] mem [FIFO_DEPTH];
    logic [17:0] entry, head_next;
    logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [CW-1:0] count, cnt_next;
    logic        pop, push, full;

    assign rise = ~prev_cw & codein;
    assign fall = prev_cw & ~codein;
    assign viol = |((rise[23:1] & fall[24:2]) | (fall[23:1] & rise[24:2]));

    // Stage 1: capture the codeword and its transition check against the last accepted word.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_cw  <= '0;
            s1_cw    <= '0;
            s1_viol  <= 1'b0;
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= cw_valid;
            if (cw_valid) begin
                s1_cw   <= codein;
                s1_viol <= viol;
                prev_cw <= codein;
            end
        end
    end

    nbcac_17di_decoder_core u_dec (.d(s1_cw), .v(dec));

`ifdef NBCAC_RX_DATAIN_CHECK_EN
    logic [24:1] reenc;
    nbcac_17di_encoder_core u_enc (.v(dec), .d(reenc));
    assign bad = s1_viol | (reenc != s1_cw);
`else
    assign bad = s1_viol;
`endif

    assign entry     = {dec, bad};
    assign out_valid = count != '0;
    assign full      = count == CW'(FIFO_DEPTH);
    assign pop       = out_valid & out_ready;
    assign push      = s1_valid & (~full | pop);
    assign rd_next   = pop ? rd_ptr + PW'(1) : rd_ptr;
    assign cnt_next  = count + CW'(push) - CW'(pop);
    // When the queue drains to nothing but the incoming word, that word becomes the head directly.
    assign head_next = (count == CW'(pop)) ? entry : mem[rd_next];

    // FIFO storage; no reset needed because the count qualifies every read.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= entry;
    end

    // FIFO pointers, occupancy and the registered head, which holds its value while empty.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            dataout <= '0;
            xt_err  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_next;
            count  <= cnt_next;
            if (cnt_next != '0) {dataout, xt_err} <= head_next;
        end
    end

    // Statistics: sticky drop flag and saturating violation count; a clear beats any update.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else if (clr_stat) begin
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            if (s1_valid & ~push) overflow <= 1'b1;
            if (push & bad & ~&err_count) err_count <= err_count + ERRCNT_W'(1);
        end
    end
endmodule

// File: tb/tb_nbcac_decoder_rx_24.sv
// tb_nbcac_decoder_rx_24: scoreboard bench for nbcac_decoder_rx_24 (default build, depth 4).
module tb_nbcac_decoder_rx_24;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:1] codein = '0;
    logic        cw_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_stat = 1'b0;
    logic [16:0] dataout;
    logic        xt_err, out_valid, overflow;
    logic [7:0]  err_count;

    nbcac_decoder_rx_24 #(.FIFO_DEPTH(DEPTH), .ERRCNT_W(8)) dut (
        .clock(clock), .rst_n(rst_n), .codein(codein), .cw_valid(cw_valid),
        .dataout(dataout), .xt_err(xt_err), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .err_count(err_count), .clr_stat(clr_stat)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    int          m_cnt;
    logic        m_s1v;
    logic [17:0] m_s1e;
    logic [24:1] m_prev;
    logic        m_ovf;
    int          m_err;
    int          pos [17] = '{1, 2, 4, 5, 7, 8, 10, 11, 13, 14, 16, 17, 19, 20, 22, 23, 24};

    function automatic logic [16:0] mdec(input logic [24:1] c);
        logic [16:0] r;
        for (int k = 0; k < 17; k++) r[k] = c[pos[k]];
        return r;
    endfunction

    function automatic logic mviol(input logic [24:1] o, input logic [24:1] n);
        for (int i = 1; i <= 23; i++) begin
            if (!o[i] && n[i] && o[i+1] && !n[i+1]) return 1'b1;
            if (o[i] && !n[i] && !o[i+1] && n[i+1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        got_q.delete();
        m_cnt = 0; m_s1v = 1'b0; m_s1e = '0; m_prev = '0; m_ovf = 1'b0; m_err = 0;
    endtask

    // One clock: drive inputs after a falling edge, log any DUT pop, advance the reference model.
    task automatic step(input logic v, input logic [24:1] cw, input logic rdy, input logic clr);
        logic pop, acc;
        cw_valid = v; codein = cw; out_ready = rdy; clr_stat = clr;
        #1;
        if (out_valid && rdy) got_q.push_back({dataout, xt_err});
        pop = (m_cnt > 0) && rdy;
        acc = m_s1v && (m_cnt < DEPTH || pop);
        if (acc) exp_q.push_back(m_s1e);
        if (clr) begin
            m_ovf = 1'b0; m_err = 0;
        end else begin
            if (m_s1v && !acc) m_ovf = 1'b1;
            if (acc && m_s1e[0] && m_err < 255) m_err++;
        end
        m_cnt = m_cnt + int'(acc) - int'(pop);
        if (v) begin
            m_s1e = {mdec(cw), mviol(m_prev, cw)};
            m_prev = cw;
        end
        m_s1v = v;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(negedge clock);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (dataout !== 17'h0) begin n_bad++; $display("FAIL reset_dataout got=%h exp=0", dataout); end
        n_cmp++; if (xt_err !== 1'b0) begin n_bad++; $display("FAIL reset_xt_err got=%b exp=0", xt_err); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        n_cmp++; if (err_count !== 8'h0) begin n_bad++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
        rst_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [17:0] g, e;
        step(1'b1, 24'h000003, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_latency_early got=%b exp=0", out_valid); end
        step(1'b0, 24'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
        n_cmp++; if (dataout !== 17'h00003) begin n_bad++; $display("FAIL basic_dataout got=%h exp=00003", dataout); end
        n_cmp++; if (xt_err !== 1'b0) begin n_bad++; $display("FAIL basic_xt_err got=%b exp=0", xt_err); end
        repeat (3) step(1'b0, 24'h0, 1'b1, 1'b0);
        n_cmp++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL basic_err_count got=%0d exp=0", err_count); end
        n_cmp++; if (got_q.size() !== 1) begin n_bad++; $display("FAIL basic_pop_count got=%0d exp=1", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL basic_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_violation();
        logic [17:0] g, e, s[$];
        step(1'b1, 24'h000001, 1'b1, 1'b0);
        step(1'b1, 24'h000002, 1'b1, 1'b0);
        step(1'b1, 24'h000006, 1'b1, 1'b0);
        repeat (5) step(1'b0, 24'h0, 1'b1, 1'b0);
        s = got_q;
        n_cmp++; if (s.size() !== 3) begin n_bad++; $display("FAIL viol_pop_count got=%0d exp=3", s.size()); end
        if (s.size() >= 3) begin
            n_cmp++; if (s[1][0] !== 1'b1) begin n_bad++; $display("FAIL viol_flag_set got=%b exp=1", s[1][0]); end
            n_cmp++; if (s[2][0] !== 1'b0) begin n_bad++; $display("FAIL viol_flag_clear got=%b exp=0", s[2][0]); end
        end
        n_cmp++; if (err_count !== 8'd1) begin n_bad++; $display("FAIL viol_err_count got=%0d exp=1", err_count); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL viol_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_overflow();
        logic [17:0] g, e;
        for (int i = 0; i < 6; i++) step(1'b1, 24'h000010 << i, 1'b0, 1'b0);
        step(1'b0, 24'h0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_out_valid got=%b exp=1", out_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL ovf_err_count got=%0d exp=%0d", err_count, m_err); end
        repeat (8) step(1'b0, 24'h0, 1'b1, 1'b0);
        n_cmp++; if (got_q.size() !== 4) begin n_bad++; $display("FAIL ovf_pop_count got=%0d exp=4", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL ovf_order got=%h exp=%h", g, e); end
        end
        step(1'b0, 24'h0, 1'b0, 1'b1);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [17:0] g, e;
        for (int i = 0; i < 4; i++) step(1'b1, 24'(32'h00A5A5 + i * 32'h111), 1'b0, 1'b0);
        step(1'b0, 24'h0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 24'($urandom), 1'b1, 1'b0);
        repeat (8) step(1'b0, 24'h0, 1'b1, 1'b0);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL b2b_err_count got=%0d exp=%0d", err_count, m_err); end
        n_cmp++; if (got_q.size() !== 24) begin n_bad++; $display("FAIL b2b_pop_count got=%0d exp=24", got_q.size()); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL b2b_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_saturate();
        logic [17:0] g, e;
        for (int i = 0; i < 300; i++) step(1'b1, (i % 2) ? 24'h000002 : 24'h000001, 1'b1, 1'b0);
        n_cmp++; if (err_count !== 8'hFF) begin n_bad++; $display("FAIL sat_err_count got=%0d exp=255", err_count); end
        step(1'b1, 24'h000001, 1'b1, 1'b1);
        n_cmp++; if (err_count !== 8'h00) begin n_bad++; $display("FAIL sat_clear_wins got=%0d exp=0", err_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL sat_overflow got=%b exp=0", overflow); end
        repeat (4) step(1'b0, 24'h0, 1'b1, 1'b0);
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL sat_after_clear got=%0d exp=%0d", err_count, m_err); end
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL sat_order got=%h exp=%h", g, e); end
        end
    endtask

    task automatic test_midreset();
        logic [17:0] g, e;
        step(1'b1, 24'h000001, 1'b0, 1'b0);
        step(1'b1, 24'h000002, 1'b0, 1'b0);
        step(1'b1, 24'h000001, 1'b0, 1'b0);
        step(1'b0, 24'h0, 1'b0, 1'b0);
        n_cmp++; if (err_count !== 8'(m_err)) begin n_bad++; $display("FAIL mrst_pre_err got=%0d exp=%0d", err_count, m_err); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (dataout !== 17'h0) begin n_bad++; $display("FAIL mrst_dataout got=%h exp=0", dataout); end
        n_cmp++; if (xt_err !== 1'b0) begin n_bad++; $display("FAIL mrst_xt_err got=%b exp=0", xt_err); end
        n_cmp++; if (err_count !== 8'h0) begin n_bad++; $display("FAIL mrst_err_count got=%0d exp=0", err_count); end
        model_reset();
        @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);
        step(1'b1, 24'h000001, 1'b1, 1'b0);
        step(1'b0, 24'h0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mrst_next_valid got=%b exp=1", out_valid); end
        n_cmp++; if (xt_err !== 1'b0) begin n_bad++; $display("FAIL mrst_next_xt got=%b exp=0", xt_err); end
        n_cmp++; if (dataout !== 17'h00001) begin n_bad++; $display("FAIL mrst_next_data got=%h exp=00001", dataout); end
        repeat (3) step(1'b0, 24'h0, 1'b1, 1'b0);
        while (got_q.size() > 0) begin
            g = got_q.pop_front();
            if (exp_q.size() > 0) e = exp_q.pop_front(); else e = 'x;
            n_cmp++; if (g !== e) begin n_bad++; $display("FAIL mrst_order got=%h exp=%h", g, e); end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_violation();
        test_overflow();
        test_back_to_back();
        test_saturate();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nbcac_decoder_rx_24.md
Name: nbcac_decoder_rx_24

Overview:
- Receive-side stage directly downstream of the 24-bit NBCAC encoder register.
- Samples the 24-wire crosstalk-avoidance codeword bus each cycle that `cw_valid` is high.
- Checks the new codeword against the previously accepted codeword for forbidden adjacent opposite transitions.
- Decodes the 24-bit codeword back to 17-bit data using the team's combinational core `nbcac_17di_decoder_core` (ports `.d[24:1]` in, `.v[16:0]` out).
- Buffers results in a small FIFO with a valid/ready interface toward the consumer.

Parameters:
- FIFO_DEPTH, 4: number of decoded entries buffered. Power of two, minimum 2.
- ERRCNT_W, 8: width of the saturating violation counter.

Ports:
- clock  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- codein  input  24 [24:1]  codeword bus from the encoder register.
- cw_valid  input  1  `codein` holds a new codeword this cycle.
- dataout  output  17 [16:0]  decoded data at the FIFO head.
- xt_err  output  1  crosstalk violation flag for the head entry.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head entry.
- overflow  output  1  sticky flag: a word was dropped because the FIFO was full.
- err_count  output  ERRCNT_W  saturating count of accepted words with a violation.
- clr_stat  input  1  synchronous clear of `overflow` and `err_count`.

Behaviour:
- Reset (async, rst_n=0):
  - `prev_cw` = 24'h0; stage-1 valid = 0.
  - FIFO empty: `out_valid`=0, `dataout`=0, `xt_err`=0.
  - `overflow`=0, `err_count`=0.
  - Reset mid-operation discards all in-flight words.
- Stage 1, on each edge with `cw_valid`=1:
  - Register `codein` and stage-1 valid = 1.
  - Compute the violation bit from `prev_cw` (old) and `codein` (new):
    - r = ~old & new; f = old & ~new.
    - viol = OR over i=1..23 of (r[i]&f[i+1]) | (f[i]&r[i+1]).
  - Update `prev_cw` <= `codein` on the same edge.
  - With `cw_valid`=0, stage-1 valid <= 0 and `prev_cw` holds.
- Stage 2:
  - When stage-1 valid is set, push {core decode of the stage-1 word, viol} into the FIFO on the next edge.
  - `dataout` and `xt_err` are driven from the FIFO head register.
- Latency: `cw_valid` high before edge N gives `out_valid`=1 after edge N+1, provided the FIFO was empty. There is no bypass path.
- Throughput: one word per cycle.
- Pop occurs when `out_valid` & `out_ready`.
- FIFO full and push pending:
  - If a pop happens in the same cycle, the push succeeds.
  - Otherwise the word is dropped and `overflow` <= 1 (sticky).
  - `err_count` counts only words actually pushed.
- `err_count` increments by 1 on every successful push with viol=1 and saturates at all-ones (no wrap).
- `clr_stat` clears both statistics. If an increment coincides with `clr_stat`, the result is 0; clear wins.
- Pointers are log2(FIFO_DEPTH) bits wide with a separate count register. They wrap from FIFO_DEPTH-1 to 0.
- Empty FIFO: `dataout` and `xt_err` hold their last popped values (0 after reset). `out_ready` is ignored.

Optional Feature:
- Macro: NBCAC_RX_DATAIN_CHECK_EN.
- Defined:
  - Stage 2 also runs `codein`'s decode through the team's encoder core `nbcac_17di_encoder_core`.
  - It compares the re-encoded word with the stage-1 codeword.
  - A mismatch (non-codeword received) is ORed into the pushed `xt_err` bit and counted in `err_count`.
  - Adds one combinational encoder instance; latency is unchanged.
- Undefined: only the transition check sets `xt_err`; no encoder instance is present.

Test Plan:
- Reset release, then `cw_valid`=1 with 24'h000003 (prev 0), `out_ready`=1 → `out_valid` high two edges later, `dataout` equals the core model decode, `xt_err`=0, `err_count`=0.
- Accept 24'h000001, then 24'h000002 (bit1 falls, bit2 rises) → second entry has `xt_err`=1 and `err_count`=1. A following 24'h000006 gives `xt_err`=0.
- `out_ready`=0 and 6 back-to-back valid words with FIFO_DEPTH=4 → 4 stored, 2 dropped, `overflow`=1. Draining returns the first 4 words in order.
- FIFO full with `out_ready`=1 and `cw_valid`=1 continuously for 20 cycles → no drops, `overflow` stays 0, ordering preserved across pointer wrap.
- Force 300 violating words with ERRCNT_W=8 → `err_count` saturates at 255. Then `clr_stat`=1 on a cycle with a violating push → `err_count`=0 and `overflow`=0.
- Assert rst_n=0 mid-stream with 3 entries queued → `out_valid`, `dataout`, `xt_err` and `err_count` go to 0 immediately. `prev_cw`=0, so a next word of 24'h000001 shows no violation.
